// File: rtl/sfm_den_inv_scheduler.sv
// Round-robin arbiter sharing one denominator inverter among NUM_REQ softmax lanes.
// Issue and return paths are combinational (zero added latency); an in-order ID FIFO routes results home.
module sfm_den_inv_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int DEN_WIDTH       = 32,
  parameter int INV_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic                           drain_i,
  output logic                           drain_done_o,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*DEN_WIDTH-1:0]   req_den_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  input  logic [NUM_REQ-1:0]             rsp_ready_i,
  output logic [INV_WIDTH-1:0]           rsp_inv_o,
  output logic                           inv_valid_o,
  input  logic                           inv_ready_i,
  output logic [DEN_WIDTH-1:0]           inv_den_o,
  input  logic                           inv_valid_i,
  output logic                           inv_ready_o,
  input  logic [INV_WIDTH-1:0]           inv_res_i,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_err;

  logic               w_live;
  logic               w_can_issue;
  logic               w_any;
  logic [ID_W-1:0]    w_grant;
  logic               w_issue;
  logic               w_nonempty;
  logic [ID_W-1:0]    w_head;
  logic               w_pop;
  logic [CNT_W-1:0]   w_count_nxt;
  int                 w_idx;

  // Nothing may be issued or retired while reset/clear is asserted: the FIFO is being wiped.
  assign w_live      = !rst_i && !clear_i;
  assign w_nonempty  = (r_count != '0);
  assign w_can_issue = w_live && (r_state == S_IDLE || r_state == S_RUN) && !drain_i && (r_count < FULL);

  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_any && req_valid_i[ID_W'(w_idx)]) begin
        w_any   = 1'b1;
        w_grant = ID_W'(w_idx);
      end
    end
  end

  assign inv_valid_o = w_can_issue && w_any;
  assign w_issue     = inv_valid_o && inv_ready_i;
  assign inv_den_o   = inv_valid_o ? req_den_i[int'(w_grant)*DEN_WIDTH +: DEN_WIDTH] : '0;

  always_comb begin
    req_ready_o = '0;
    if (w_issue) req_ready_o[w_grant] = 1'b1;
  end

  assign w_head      = r_fifo[r_rd_ptr];
  assign inv_ready_o = w_live && w_nonempty && rsp_ready_i[w_head];
  assign w_pop       = inv_valid_i && inv_ready_o;
  assign rsp_inv_o   = inv_res_i;

  always_comb begin
    rsp_valid_o = '0;
    if (w_live && inv_valid_i && w_nonempty) rsp_valid_o[w_head] = 1'b1;
  end

  // Full check uses the registered count, so a pop in the same cycle never frees a slot early.
  assign w_count_nxt = r_count + CNT_W'(w_issue) - CNT_W'(w_pop);

  always_comb begin
    w_state_nxt  = r_state;
    drain_done_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (drain_i)      w_state_nxt = S_DONE;
        else if (w_issue) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (drain_i)                               w_state_nxt = S_DRAIN;
        else if (w_count_nxt == '0 && !w_issue)    w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (w_count_nxt == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        drain_done_o = w_live;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy_o = (r_state != S_IDLE);
  assign err_o  = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else if (clear_i) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_issue) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_ptr    <= (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + ID_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (inv_valid_i && !w_nonempty) r_err <= 1'b1;
    end
  end

  // ID storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge clk_i) begin
    if (w_issue) r_fifo[r_wr_ptr] <= w_grant;
  end

endmodule

// File: tb/tb_sfm_den_inv_scheduler.sv
// Directed and random checks of sfm_den_inv_scheduler against a queue-based reference model.
module tb_sfm_den_inv_scheduler;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int IW = 16;
  localparam int MO = 4;

  logic              clk_i = 1'b0;
  logic              rst_i, clear_i, drain_i, drain_done_o;
  logic [NR-1:0]     req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [NR*DW-1:0]  req_den_i;
  logic [IW-1:0]     rsp_inv_o, inv_res_i;
  logic              inv_valid_o, inv_ready_i, inv_valid_i, inv_ready_o, busy_o, err_o;
  logic [DW-1:0]     inv_den_o;

  always #5 clk_i = ~clk_i;

  sfm_den_inv_scheduler #(.NUM_REQ(NR), .DEN_WIDTH(DW), .INV_WIDTH(IW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .drain_i(drain_i), .drain_done_o(drain_done_o),
    .req_valid_i(req_valid_i), .req_den_i(req_den_i), .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_inv_o(rsp_inv_o),
    .inv_valid_o(inv_valid_o), .inv_ready_i(inv_ready_i), .inv_den_o(inv_den_o),
    .inv_valid_i(inv_valid_i), .inv_ready_o(inv_ready_o), .inv_res_i(inv_res_i),
    .busy_o(busy_o), .err_o(err_o));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: outstanding IDs in issue order plus a few mode flags.
  int m_q[$];
  int m_ptr;
  bit m_err, m_busy, m_draining, m_done;
  // Bench inverter: results become visible two cycles after issue, held until accepted.
  logic [IW-1:0] iv_val[$];
  int iv_age[$];
  bit use_inv;
  int dut_iss[$], dut_rsp[$];
  int last_pop_cyc, done_cyc, both_cnt;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ptr = 0; m_err = 0; m_busy = 0; m_draining = 0; m_done = 0;
    iv_val.delete(); iv_age.delete();
  endtask

  function automatic logic [IW-1:0] inv_of(input logic [DW-1:0] d);
    return d[15:0] ^ d[31:16] ^ 16'h5A5A;
  endfunction

  function automatic logic [NR*DW-1:0] rand_dens();
    logic [NR*DW-1:0] v;
    for (int r = 0; r < NR; r++) v[r*DW +: DW] = $urandom;
    return v;
  endfunction

  task automatic cycle();
    bit live, can, found, iss, pop, was_empty, exp_done;
    int g, head, n;
    logic [NR-1:0] exp_rr, exp_rv;
    logic [DW-1:0] exp_den;
    bit exp_ir;
    if (use_inv) begin
      inv_valid_i = (iv_val.size() > 0) && (iv_age[0] >= 1);
      inv_res_i   = inv_valid_i ? iv_val[0] : '0;
    end
    @(negedge clk_i);
    live  = !clear_i;
    can   = live && !m_done && !m_draining && !drain_i && (m_q.size() < MO);
    found = 0; g = 0;
    for (int k = 0; k < NR; k++) begin
      int r;
      r = (m_ptr + k) % NR;
      if (!found && req_valid_i[r]) begin found = 1; g = r; end
    end
    iss     = can && found && inv_ready_i;
    exp_den = (can && found) ? req_den_i[g*DW +: DW] : '0;
    exp_rr  = '0;
    if (iss) exp_rr[g] = 1'b1;
    exp_rv = '0; exp_ir = 0;
    was_empty = (m_q.size() == 0);
    if (live && !was_empty) begin
      head   = m_q[0];
      exp_ir = rsp_ready_i[head];
      if (inv_valid_i) exp_rv[head] = 1'b1;
    end
    pop      = inv_valid_i && exp_ir;
    exp_done = m_done && live;
    chk("inv_valid_o", inv_valid_o, can && found);
    chk("inv_den_o", inv_den_o, exp_den);
    chk("req_ready_o", req_ready_o, exp_rr);
    chk("rsp_valid_o", rsp_valid_o, exp_rv);
    chk("inv_ready_o", inv_ready_o, exp_ir);
    chk("rsp_inv_o", rsp_inv_o, inv_res_i);
    chk("drain_done_o", drain_done_o, exp_done);
    chk("busy_o", busy_o, m_busy);
    chk("err_o", err_o, m_err);
    for (int r = 0; r < NR; r++) if (req_ready_o[r]) dut_iss.push_back(r);
    if (inv_valid_i && inv_ready_o)
      for (int r = 0; r < NR; r++) if (rsp_valid_o[r]) dut_rsp.push_back(r);
    if (req_ready_o != '0 && rsp_valid_o != '0 && inv_ready_o) both_cnt++;
    if (drain_done_o) done_cyc = cyc;
    if (inv_valid_i && inv_ready_o) last_pop_cyc = cyc;
    if (clear_i) begin
      model_reset();
    end else begin
      if (iss) begin m_q.push_back(g); m_ptr = (g + 1) % NR; end
      if (pop) void'(m_q.pop_front());
      if (inv_valid_i && was_empty) m_err = 1;
      n = m_q.size();
      if (m_done) begin
        m_done = 0; m_busy = 0;
      end else if (m_draining) begin
        if (n == 0) begin m_draining = 0; m_done = 1; end
      end else if (!m_busy) begin
        if (drain_i) begin m_done = 1; m_busy = 1; end
        else if (iss) m_busy = 1;
      end else begin
        if (drain_i) m_draining = 1;
        else if (n == 0 && !iss) m_busy = 0;
      end
      if (use_inv) begin
        if (pop) begin void'(iv_val.pop_front()); void'(iv_age.pop_front()); end
        foreach (iv_age[i]) iv_age[i]++;
        if (iss) begin iv_val.push_back(inv_of(req_den_i[g*DW +: DW])); iv_age.push_back(0); end
      end
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_i = 1; clear_i = 0; drain_i = 0; req_valid_i = '0; req_den_i = rand_dens();
    rsp_ready_i = '1; inv_ready_i = 1; inv_valid_i = 0; inv_res_i = '0; use_inv = 1;
    last_pop_cyc = -1; done_cyc = -1; both_cnt = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 0;
    run(2);

    // Fairness: all lanes valid, inverter always ready.
    dut_iss.delete(); dut_rsp.delete();
    req_valid_i = '1;
    run(5);
    req_valid_i = '0;
    run(6);
    chk("fair_n_iss", dut_iss.size(), 5);
    chk("fair_n_rsp", dut_rsp.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("fair_iss_order", (i < dut_iss.size()) ? dut_iss[i] : -1, exp_order[i]);
      chk("fair_rsp_order", (i < dut_rsp.size()) ? dut_rsp[i] : -1, exp_order[i]);
    end

    // Reset mid-traffic: pointer advanced to 3, then wiped.
    req_valid_i = '1; req_den_i = rand_dens();
    run(2);
    rst_i = 1;
    #1;
    chk("rst_inv_valid", inv_valid_o, 0);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_inv_ready", inv_ready_o, 0);
    chk("rst_inv_den", inv_den_o, 0);
    chk("rst_drain_done", drain_done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 0;
    model_reset();
    dut_iss.delete();
    run(1);
    chk("rst_first_grant", (dut_iss.size() > 0) ? dut_iss[0] : -1, 0);
    req_valid_i = '0;
    run(5);

    // Backpressure: lane 1 stalls its result, FIFO fills to MO.
    dut_iss.delete(); dut_rsp.delete();
    req_valid_i = '1; req_den_i = rand_dens(); rsp_ready_i = 4'b1101;
    run(5);
    chk("bp_full_no_issue", inv_valid_o, 0);
    chk("bp_n_iss", dut_iss.size(), 4);
    req_valid_i = '0; rsp_ready_i = '1;
    run(10);
    chk("bp_n_rsp", dut_rsp.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("bp_rsp_order", (i < dut_rsp.size()) ? dut_rsp[i] : -1, (1 + i) % NR);

    // Steady push+pop at count 2.
    dut_iss.delete(); dut_rsp.delete(); both_cnt = 0;
    req_valid_i = '1; req_den_i = rand_dens();
    run(12);
    chk("pp_both_fire", both_cnt, 10);
    req_valid_i = '0;
    run(6);
    chk("pp_n_iss", dut_iss.size(), 12);
    chk("pp_n_rsp", dut_rsp.size(), 12);
    for (int i = 0; i < 12; i++) begin
      chk("pp_iss_order", (i < dut_iss.size()) ? dut_iss[i] : -1, (1 + i) % NR);
      chk("pp_rsp_order", (i < dut_rsp.size()) ? dut_rsp[i] : -1, (1 + i) % NR);
    end

    // Drain with three outstanding.
    dut_iss.delete(); dut_rsp.delete();
    rsp_ready_i = '0; req_valid_i = '1; req_den_i = rand_dens();
    run(3);
    drain_i = 1;
    run(3);
    chk("drain_no_issue", dut_iss.size(), 3);
    rsp_ready_i = '1; done_cyc = -1;
    for (int i = 0; i < 20 && done_cyc < 0; i++) cycle();
    req_valid_i = '0; drain_i = 0;
    chk("drain_done_seen", done_cyc >= 0, 1);
    chk("drain_done_delay", done_cyc - last_pop_cyc, 1);
    chk("drain_n_pops", dut_rsp.size(), 3);
    chk("drain_busy_fall", busy_o, 0);
    chk("drain_pulse_width", drain_done_o, 0);
    run(2);

    // Spurious result with empty FIFO.
    use_inv = 0; inv_valid_i = 1; inv_res_i = 16'h1234;
    run(1);
    inv_valid_i = 0; inv_res_i = '0;
    run(2);
    chk("spur_err_sticky", err_o, 1);
    clear_i = 1;
    run(1);
    clear_i = 0;
    chk("spur_err_cleared", err_o, 0);
    use_inv = 1;
    run(1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req_valid_i = NR'($urandom);
      req_den_i   = rand_dens();
      inv_ready_i = ($urandom_range(0, 3) != 0);
      rsp_ready_i = NR'($urandom);
      drain_i     = ($urandom_range(0, 15) == 0);
      clear_i     = ($urandom_range(0, 63) == 0);
      cycle();
    end
    clear_i = 0; drain_i = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
